user_bram_wb: RTL and testbench

USER_BRAM_WB -- requirements
Module: user_bram_wb

---
 rtl/user_bram_pkg.sv | 13 +
 rtl/bram32.sv | 25 ++
 rtl/user_bram_wb.sv | 120 ++++++++++++
 tb/tb_user_bram_wb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/user_bram_pkg.sv
// Shared definitions for the Wishbone-attached user BRAM: FSM states, address window, data width.
package user_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    localparam logic [7:0] BRAM_BASE_HI = 8'h38;
    localparam int         DATA_W       = 32;

endpackage

// File: rtl/bram32.sv
// Single-port 32-bit block RAM: one-cycle synchronous read, per-byte write enables, contents not reset.
module bram32
    import user_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/user_bram_wb.sv
// Wishbone classic slave fronting a bram32 with DELAYS wait states per access.
// Optional logic-analyzer monitor enabled by defining USER_BRAM_LA_MON_EN.
module user_bram_wb
    import user_bram_pkg::*;
#(
    parameter int DELAYS     = 10,
    parameter int ADDR_WIDTH = 10
) (
    input  logic         wb_clk_i,
    input  logic         wb_rstn_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [127:0] la_data_out
);

    state_t                  state;
    logic [7:0]              cnt;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    we_r;
    logic [3:0]              sel_r;
    logic [DATA_W-1:0]       dat_r;
    logic [DATA_W-1:0]       rdata;
    logic                    active;
    logic                    hit;
    logic                    last_wait;
    logic [3:0]              bram_we;
    logic                    unused_adr;

    assign active     = wbs_stb_i & wbs_cyc_i;
    assign hit        = active & (wbs_adr_i[31:24] == BRAM_BASE_HI);
    assign last_wait  = (state == ST_WAIT) && (cnt == 8'(DELAYS - 1));
    // The write commits on the WAIT->ACK edge, so an abort in the last wait cycle still suppresses it.
    assign bram_we    = (last_wait && active && we_r) ? sel_r : 4'b0000;
    assign unused_adr = ^{wbs_adr_i[23:ADDR_WIDTH+2], wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            addr_r    <= '0;
            we_r      <= 1'b0;
            sel_r     <= 4'b0000;
            dat_r     <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state  <= ST_WAIT;
                        cnt    <= 8'd0;
                        addr_r <= wbs_adr_i[ADDR_WIDTH+1:2];
                        we_r   <= wbs_we_i;
                        sel_r  <= wbs_sel_i;
                        dat_r  <= wbs_dat_i;
                    end
                end
                ST_WAIT: begin
                    if (!active) begin
                        state <= ST_IDLE;
                        cnt   <= 8'd0;
                    end else if (last_wait) begin
                        state <= ST_ACK;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_ACK: begin
                    // BRAM output for the registered address is valid during this state.
                    wbs_ack_o <= 1'b1;
                    wbs_dat_o <= we_r ? '0 : rdata;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bram32 #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
        .clk   (wb_clk_i),
        .we    (bram_we),
        .addr  (addr_r),
        .wdata (dat_r),
        .rdata (rdata)
    );

`ifdef USER_BRAM_LA_MON_EN
    logic [31:0] mon_wdata;
    logic [31:0] mon_addr;
    logic [31:0] mon_count;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            mon_wdata <= '0;
            mon_addr  <= '0;
            mon_count <= '0;
        end else if (state == ST_ACK) begin
            mon_count <= mon_count + 32'd1;
            mon_addr  <= 32'(addr_r);
            if (we_r) begin
                mon_wdata <= dat_r;
            end
        end
    end

    assign la_data_out = {32'h0, mon_count, mon_addr, mon_wdata};
`else
    assign la_data_out = '0;
`endif

endmodule

// File: tb/tb_user_bram_wb.sv
// Bench for user_bram_wb: Wishbone driver tasks, reference memory model and read-data scoreboard.
module tb_user_bram_wb;

    localparam int DELAYS = 10;
    localparam int AW     = 10;

    logic         clk;
    logic         rst_n;
    logic         stb;
    logic         cyc;
    logic         we;
    logic [3:0]   sel;
    logic [31:0]  adr;
    logic [31:0]  dat_i;
    logic         ack;
    logic [31:0]  dat_o;
    logic [127:0] la;

    user_bram_wb #(.DELAYS(DELAYS), .ADDR_WIDTH(AW)) dut (
        .wb_clk_i    (clk),
        .wb_rstn_i   (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .la_data_out (la)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model [int];
    logic [31:0] la_cnt;
    logic [31:0] la_addr;
    logic [31:0] la_wdata;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] la_exp();
`ifdef USER_BRAM_LA_MON_EN
        return {32'h0, la_cnt, la_addr, la_wdata};
`else
        return 128'h0;
`endif
    endfunction

    task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        adr   = a;
        we    = w;
        sel   = s;
        dat_i = d;
        stb   = 1'b1;
        cyc   = 1'b1;
    endtask

    task automatic release_bus();
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
    endtask

    task automatic la_reset();
        la_cnt   = '0;
        la_addr  = '0;
        la_wdata = '0;
    endtask

    // Called at a negedge; runs one transaction and scores it at the acknowledge.
    task automatic wb_cycle(input string tag, input logic [31:0] a, input logic w,
                            input logic [3:0] s, input logic [31:0] d, input bit hold);
        int          n;
        int          word;
        logic [31:0] m;
        word = int'(a[AW+1:2]);
        drive(a, w, s, d);
        if (!w) exp_q.push_back(model[word]);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!ack && n < 200);
        check({tag, " latency"}, 128'(n - 1), 128'(DELAYS + 1));
        if (ack) begin
            if (w) begin
                m = model.exists(word) ? model[word] : 32'hx;
                for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = d[8*i +: 8];
                model[word] = m;
                la_wdata = d;
            end else begin
                check({tag, " rdata"}, 128'(dat_o), 128'(exp_q.pop_front()));
            end
            la_cnt++;
            la_addr = 32'(word);
            check({tag, " la"}, la, la_exp());
        end else if (!w) begin
            void'(exp_q.pop_front());
        end
        if (!hold) begin
            release_bus();
            @(negedge clk);
            check({tag, " ack single"}, 128'(ack), 128'(0));
            check({tag, " dat idle"}, 128'(dat_o), 128'(0));
        end
    endtask

    task automatic count_acks(input int cycles, output int acks);
        acks = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ack) acks++;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          acks;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        w;

        rst_n = 1'b0;
        release_bus();
        sel   = 4'h0;
        adr   = '0;
        dat_i = '0;
        la_reset();
        repeat (3) @(negedge clk);
        check("reset ack", 128'(ack), 128'(0));
        check("reset dat", 128'(dat_o), 128'(0));
        check("reset la", la, 128'h0);

        // First hit accepted on the first edge after release.
        rst_n = 1'b1;
        wb_cycle("wr 0x04", 32'h3800_0004, 1'b1, 4'hF, 32'h1234_5678, 1'b0);
        wb_cycle("rd 0x04", 32'h3800_0004, 1'b0, 4'hF, 32'h0, 1'b0);

        // Byte-lane masking.
        wb_cycle("wr 0x08 pre", 32'h3800_0008, 1'b1, 4'hF, 32'h1122_3344, 1'b0);
        wb_cycle("wr 0x08 sel", 32'h3800_0008, 1'b1, 4'b0010, 32'hAABB_CCDD, 1'b0);
        wb_cycle("rd 0x08", 32'h3800_0008, 1'b0, 4'hF, 32'h0, 1'b0);
        check("byte mask value", 128'(model[2]), 128'(32'h1122_CC44));

        // Outside the window: never acknowledged, memory untouched.
        wb_cycle("wr 0x00", 32'h3800_0000, 1'b1, 4'hF, 32'h0BAD_F00D, 1'b0);
        drive(32'h3000_0000, 1'b1, 4'hF, 32'h55AA_55AA);
        count_acks(50, acks);
        check("miss ack count", 128'(acks), 128'(0));
        release_bus();
        @(negedge clk);
        wb_cycle("rd 0x00 after miss", 32'h3800_0000, 1'b0, 4'hF, 32'h0, 1'b0);

        // Abort by dropping cyc in the fifth wait cycle.
        drive(32'h3800_0004, 1'b1, 4'hF, 32'hDEAD_BEEF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        cyc = 1'b0;
        count_acks(20, acks);
        check("abort ack count", 128'(acks), 128'(0));
        release_bus();
        @(negedge clk);
        wb_cycle("rd 0x04 after abort", 32'h3800_0004, 1'b0, 4'hF, 32'h0, 1'b0);

        // Reset in the third wait cycle of a write.
        drive(32'h3800_0008, 1'b1, 4'hF, 32'hCAFE_F00D);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        release_bus();
        count_acks(5, acks);
        check("reset mid ack count", 128'(acks), 128'(0));
        check("reset mid dat", 128'(dat_o), 128'(0));
        check("reset mid la", la, 128'h0);
        la_reset();
        rst_n = 1'b1;
        count_acks(15, acks);
        check("post reset ack count", 128'(acks), 128'(0));
        wb_cycle("rd 0x08 after reset", 32'h3800_0008, 1'b0, 4'hF, 32'h0, 1'b0);

        // Three acknowledged accesses since reset, the last a write to word 2.
        wb_cycle("rd 0x00 mon", 32'h3800_0000, 1'b0, 4'hF, 32'h0, 1'b0);
        wb_cycle("wr 0x08 mon", 32'h3800_0008, 1'b1, 4'hF, 32'h0000_ABCD, 1'b0);
`ifdef USER_BRAM_LA_MON_EN
        check("la count", 128'(la[95:64]), 128'(3));
        check("la addr", 128'(la[63:32]), 128'(2));
        check("la wdata", 128'(la[31:0]), 128'(32'h0000_ABCD));
        check("la top", 128'(la[127:96]), 128'(0));
`else
        check("la disabled", la, 128'h0);
`endif

        // Back-to-back: stb held through the acknowledge starts the next access at minimum spacing.
        wb_cycle("b2b first", 32'h3800_0004, 1'b0, 4'hF, 32'h0, 1'b1);
        wb_cycle("b2b second", 32'h3800_0008, 1'b0, 4'hF, 32'h0, 1'b0);

        // Random traffic over words 0..15 with aliased upper address bits.
        for (int k = 0; k < 16; k++) begin
            a = {8'h38, 12'($urandom_range(0, 4095)), 6'b0, 4'(k), 2'b00};
            wb_cycle("rand init", a, 1'b1, 4'hF, $urandom, 1'b0);
        end
        for (int k = 0; k < 30; k++) begin
            a = {8'h38, 12'($urandom_range(0, 4095)), 6'b0, 4'($urandom_range(0, 15)), 2'b00};
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            wb_cycle(w ? "rand wr" : "rand rd", a, w, s, d, 1'b0);
        end

        check("scoreboard drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
